uart_rx_framed: RTL
===================

// Module: uart_rx_framed
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds configurable data width,
//  parity, 1/2 stop bits, start-bit glitch rejection, error reporting and an output FIFO.
//  Sits between the rxd pad and an AXI-stream consumer. Single clock domain; rxd is asynchronous.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per bit; must be >= 4
//  DATA_BITS      8  data bits per frame, 5..9, LSB first
//  PARITY         0  0 none, 1 odd, 2 even
//  STOP_BITS      1  1 or 2
//  FIFO_DEPTH     4  output FIFO entries; power of 2, >= 2
// PORTS
//  clk            in   1          system clock
//  reset_n        in   1          asynchronous, active-low reset
//  rxd            in   1          serial input, idle high
//  m_tdata        out  DATA_BITS  received word at FIFO head
//  m_tuser        out  2          [0] parity error, [1] framing error for m_tdata
//  m_tvalid       out  1          FIFO not empty
//  m_tready       in   1          consumer accepts beat
//  overrun        out  1          1-cycle pulse: completed frame dropped, FIFO full
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE, sync flops=1, counters 0, FIFO empty; m_tvalid=0,
//    m_tdata=0, m_tuser=0, overrun=0. Reset mid-frame discards the partial frame.
//  - rxd passes a 2-flop synchroniser (rxd_s, 2 clk latency). All sampling uses rxd_s.
//  - Bit counter width $clog2(CLKS_PER_BIT); sample point = mid-bit (count CLKS_PER_BIT/2-1
//    in START, then every CLKS_PER_BIT clocks).
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> [STOP2] -> IDLE; BREAK_WAIT.
//    IDLE: rxd_s==0 -> START, counter cleared.
//    START: at mid-bit, rxd_s==1 -> IDLE (glitch, nothing pushed); else -> DATA.
//    DATA: shift in DATA_BITS samples LSB first; then PARITY if PARITY!=0, else STOP.
//    PARITY: perr = sampled bit != expected (odd: XOR(data)^1, even: XOR(data)).
//    STOP: ferr if sample==0. STOP_BITS=2 -> STOP2, which ORs its own ferr.
//    Last stop sample: push {ferr,perr,data} in same cycle; -> IDLE if rxd_s==1, else BREAK_WAIT.
//    BREAK_WAIT: stays until rxd_s==1, then IDLE (held-low line yields exactly one frame).
//  - Return to IDLE at mid stop bit so a back-to-back start edge is never missed.
//  - FIFO: m_tdata/m_tuser = head entry; stable while m_tvalid && !m_tready.
//    Pop on m_tvalid && m_tready. Push and pop same cycle: both occur, count unchanged;
//    when full, a same-cycle pop makes room and the push is accepted.
//    Push when full with no pop: word dropped, FIFO unchanged, overrun=1 for 1 cycle.
//    Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
//  - Latency: m_tvalid rises 1 clk after the last stop-bit sample (registered FIFO).
//  - Errored frames are still delivered; consumer decides via m_tuser.
// TESTING (CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, STOP_BITS=1, FIFO_DEPTH=4)
//  1 Back-to-back frames 0x0A,0x0B,0x0C, m_tready=1 -> three beats 0x0A,0x0B,0x0C, m_tuser=0.
//  2 0x5A with parity bit 1 (expected 0) -> beat 0x5A, m_tuser=2'b01; next 0x5A correct -> 2'b00.
//  3 0x33 with stop bit 0, line low 3 bit times, then 0x44 -> one beat 0x33/2'b10, then 0x44/2'b00.
//  4 m_tready=0, frames 0x01..0x05 -> m_tvalid held, overrun pulses once on 0x05;
//    then m_tready=1 -> drains 0x01..0x04 in order, m_tvalid=0 after.
//  5 rxd low for 1 clk during idle -> no beat, FSM back in IDLE; following 0x81 received cleanly.
//  6 reset_n=0 for 2 clk mid-DATA of 0xFF, FIFO holding 1 entry -> m_tvalid=0 immediately;
//    after release, frame 0x7E -> single beat 0x7E.

Source files
------------

// File: rtl/uart_rx_framed.sv
// UART receiver with configurable framing, start-glitch rejection, per-word error flags
// and an AXI-stream output FIFO. rxd is asynchronous; everything else runs on clk.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | line idle, waiting for a low on the synchronised input
// ST_START   | timing to mid start bit; a high there is a glitch
// ST_DATA    | sampling data bits at mid-bit, LSB first
// ST_PARITY  | sampling the parity bit
// ST_STOP    | sampling the first stop bit
// ST_STOP2   | sampling the second stop bit
// ST_BREAK   | frame done but line still low; wait for it to go high
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_tdata,
  output logic [1:0]           m_tuser,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 overrun
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int EW   = DATA_BITS + 2;

  localparam logic [CW-1:0]   HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [CNTW-1:0] DEPTH    = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_STOP2,
    ST_BREAK
  } state_t;

  logic                 r_rxd_meta;
  logic                 r_rxd_s;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;

  logic                 w_tick;
  logic                 w_push;
  logic                 w_push_ferr;
  logic                 w_par_exp;

  logic [EW-1:0]        r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CNTW-1:0]      r_count;
  logic                 r_overrun;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;
  logic [EW-1:0]        w_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxd_meta <= 1'b1;
      r_rxd_s    <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_s    <= r_rxd_meta;
    end
  end

  // Bit timer terminal count marks every mid-bit sample point.
  assign w_tick    = (r_cnt == '0);
  assign w_par_exp = (PARITY == 1) ? ~(^r_shift) : (^r_shift);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_ferr = ~r_rxd_s;
    case (r_state)
      ST_IDLE: begin
        if (!r_rxd_s) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_tick) w_state_nxt = r_rxd_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_tick && (r_bit_cnt == '0))
          w_state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_tick) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick) begin
          if (STOP_BITS == 2) begin
            w_state_nxt = ST_STOP2;
          end else begin
            w_push      = 1'b1;
            w_state_nxt = r_rxd_s ? ST_IDLE : ST_BREAK;
          end
        end
      end
      ST_STOP2: begin
        if (w_tick) begin
          w_push      = 1'b1;
          w_push_ferr = r_ferr | ~r_rxd_s;
          w_state_nxt = r_rxd_s ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (r_rxd_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      // Half-bit preload while idle puts the first sample in the middle of the start bit.
      if ((r_state == ST_IDLE) || (r_state == ST_BREAK))
        r_cnt <= HALF_M1;
      else if (w_tick)
        r_cnt <= FULL_M1;
      else
        r_cnt <= r_cnt - CW'(1);

      if (r_state == ST_START) begin
        r_bit_cnt <= BIT_LAST;
        r_perr    <= 1'b0;
        r_ferr    <= 1'b0;
      end

      if ((r_state == ST_DATA) && w_tick) begin
        r_shift   <= {r_rxd_s, r_shift[DATA_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt - BW'(1);
      end

      if ((r_state == ST_PARITY) && w_tick)
        r_perr <= (r_rxd_s != w_par_exp);

      if ((r_state == ST_STOP) && w_tick)
        r_ferr <= ~r_rxd_s;
    end
  end

  assign w_full  = (r_count == DEPTH);
  assign w_pop   = m_tvalid && m_tready;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the word.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_wdata = {w_push_ferr, r_perr, r_shift};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_wdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count   <= r_count + CNTW'(w_wr) - CNTW'(w_pop);
      r_overrun <= w_push && w_full && !w_pop;
    end
  end

  assign m_tvalid = (r_count != '0);
  assign m_tdata  = r_mem[r_rd_ptr][DATA_BITS-1:0];
  assign m_tuser  = r_mem[r_rd_ptr][EW-1:DATA_BITS];
  assign overrun  = r_overrun;

endmodule
